register_file_sb: RTL

Parametrised multi-port register file for the DECODE stage, with write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard. It replaces the fixed 8×16, 2-read/1-write file. It serves N read ports and two write-back ports (ALU and memory). It also tracks in-flight destination registers so that decode can detect RAW and WAW hazards.

---
 rtl/register_file_sb_pkg.sv | 12 +
 rtl/register_file_sb_scoreboard.sv | 56 +++++
 rtl/register_file_sb.sv | 80 ++++++++
 3 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared constants for the decode-stage register file: default geometry and write-port indices.
package regfile_pkg;

    localparam int DEF_WIDTH             = 16;
    localparam int DEF_NUM_REGISTERS     = 8;
    localparam int DEF_LOG_NUM_REGISTERS = 3;

    localparam int NUM_WRITE_PORTS = 2;
    localparam int WP_ALU          = 0;
    localparam int WP_MEM          = 1;

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight destinations, refuses issue on WAW, reports operand readiness.
// Issue sets and write-back clears take effect at the edge; stall and readiness are combinational.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS     = DEF_NUM_REGISTERS,
    parameter int LOG_NUM_REGISTERS = DEF_LOG_NUM_REGISTERS,
    parameter int NUM_READ_PORTS    = 2,
    parameter int BYPASS            = 1,
    parameter int ZERO_REG          = 0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_READ_PORTS*LOG_NUM_REGISTERS-1:0] raddr,
    input  logic [NUM_WRITE_PORTS-1:0]                  we,
    input  logic [LOG_NUM_REGISTERS-1:0]                waddr0,
    input  logic [LOG_NUM_REGISTERS-1:0]                waddr1,
    input  logic                                        issue_valid,
    input  logic [LOG_NUM_REGISTERS-1:0]                issue_addr,
    output logic                                        issue_stall,
    output logic [NUM_READ_PORTS-1:0]                   rready
);

    logic [NUM_REGISTERS-1:0] busy;
    logic [NUM_REGISTERS-1:0] wr_dec;
    logic [NUM_REGISTERS-1:0] set_dec;
    logic                     issue_ok;

    assign issue_stall = issue_valid & busy[issue_addr] & ~wr_dec[issue_addr];
    assign issue_ok    = issue_valid & ~issue_stall
                         & ~((ZERO_REG != 0) && (issue_addr == '0));

    always_comb begin
        wr_dec  = '0;
        set_dec = '0;
        if (we[WP_ALU]) wr_dec[waddr0] = 1'b1;
        if (we[WP_MEM]) wr_dec[waddr1] = 1'b1;
        if (issue_ok)   set_dec[issue_addr] = 1'b1;
    end

    // Set is OR-ed in after the clear: a new producer supersedes the one retiring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_dec) | set_dec;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rdy
        logic [LOG_NUM_REGISTERS-1:0] ra;
        assign ra        = raddr[p*LOG_NUM_REGISTERS +: LOG_NUM_REGISTERS];
        assign rready[p] = ~busy[ra] | ((BYPASS != 0) & wr_dec[ra]);
    end

endmodule

// File: rtl/register_file_sb.sv
// Decode-stage register file: N combinational read ports, ALU and memory write-back ports, optional bypass and zero register.
// Reads are zero-latency; writes land at the edge; issue_stall refuses an issue whose destination is still in flight.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS     = DEF_NUM_REGISTERS,
    parameter int LOG_NUM_REGISTERS = DEF_LOG_NUM_REGISTERS,
    parameter int WIDTH             = DEF_WIDTH,
    parameter int NUM_READ_PORTS    = 2,
    parameter int BYPASS            = 1,
    parameter int ZERO_REG          = 0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_READ_PORTS*LOG_NUM_REGISTERS-1:0] raddr,
    output logic [NUM_READ_PORTS*WIDTH-1:0]             rdata,
    output logic [NUM_READ_PORTS-1:0]                   rready,
    input  logic                                        we0,
    input  logic [LOG_NUM_REGISTERS-1:0]                waddr0,
    input  logic [WIDTH-1:0]                            wdata0,
    input  logic                                        we1,
    input  logic [LOG_NUM_REGISTERS-1:0]                waddr1,
    input  logic [WIDTH-1:0]                            wdata1,
    input  logic                                        issue_valid,
    input  logic [LOG_NUM_REGISTERS-1:0]                issue_addr,
    output logic                                        issue_stall
);

    logic [NUM_WRITE_PORTS-1:0] we_eff;
    logic [WIDTH-1:0]           regs [NUM_REGISTERS];

    // Writes to the zero register are squashed here so storage, bypass and scoreboard all ignore them.
    assign we_eff[WP_ALU] = we0 & ~((ZERO_REG != 0) && (waddr0 == '0));
    assign we_eff[WP_MEM] = we1 & ~((ZERO_REG != 0) && (waddr1 == '0));

    // Memory port is applied last so it wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_eff[WP_ALU]) regs[waddr0] <= wdata0;
            if (we_eff[WP_MEM]) regs[waddr1] <= wdata1;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [LOG_NUM_REGISTERS-1:0] ra;
        logic                         hit_alu;
        logic                         hit_mem;

        assign ra      = raddr[p*LOG_NUM_REGISTERS +: LOG_NUM_REGISTERS];
        assign hit_alu = (BYPASS != 0) && we_eff[WP_ALU] && (waddr0 == ra);
        assign hit_mem = (BYPASS != 0) && we_eff[WP_MEM] && (waddr1 == ra);

        assign rdata[p*WIDTH +: WIDTH] = hit_mem ? wdata1 :
                                         hit_alu ? wdata0 : regs[ra];
    end

    regfile_scoreboard #(
        .NUM_REGISTERS     (NUM_REGISTERS),
        .LOG_NUM_REGISTERS (LOG_NUM_REGISTERS),
        .NUM_READ_PORTS    (NUM_READ_PORTS),
        .BYPASS            (BYPASS),
        .ZERO_REG          (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .raddr       (raddr),
        .we          (we_eff),
        .waddr0      (waddr0),
        .waddr1      (waddr1),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_stall (issue_stall),
        .rready      (rready)
    );

endmodule
